// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  // Count register width: clog2(ndig), never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    int w;
    w = $clog2(ndig);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit slice of the add/subtract datapath, built as a ripple of full adders.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] bx;

  assign bx   = b ^ {DIGIT{sub}};
  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor, one DIGIT-bit slice per cycle, LSB first.
// Optional build macro ADDSUB_SATURATE_EN clamps overflowing results to the signed limit.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is 1 only in IDLE, out_valid only in DONE, so accept and handoff never overlap.

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             ovf_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] res_final;

  // Operands shift right so the active slice is always the low DIGIT bits.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .sub      (sub_q),
    .cin      (carry_q),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // Result fills from the top; after NDIG shifts slice i sits at bits i*DIGIT.
  assign res_next = (result >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  assign ovf_next = dig_cmsb ^ dig_cout;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic a_msb_q;

  // On overflow the true result has the sign of A.
  assign res_final = ovf_next ? (a_msb_q ? SMIN : SMAX) : res_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_msb_q <= a[WIDTH-1];
    end
  end
`else
  assign res_final = res_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NDIG - 1)) begin
            result <= res_final;
            cout   <= dig_cout;
            ovf    <= ovf_next;
            zero   <= (res_final == '0);
            state  <= DONE;
          end else begin
            result <= res_next;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT=1,4,16; WIDTH=16) vs an arithmetic model.
module tb_digit_serial_addsub;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [W-1:0] a_i       [3];
  logic [W-1:0] b_i       [3];
  logic         sub_i     [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] result_o  [3];
  logic         cout_o    [3];
  logic         ovf_o     [3];
  logic         zero_o    [3];
  logic [1:0]   state_o   [3];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    digit_serial_addsub #(
      .WIDTH (W),
      .DIGIT ((g == 0) ? 1 : (g == 1) ? 4 : 16)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a_i[g]),
      .b         (b_i[g]),
      .sub       (sub_i[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result_o[g]),
      .cout      (cout_o[g]),
      .ovf       (ovf_o[g]),
      .zero      (zero_o[g]),
      .dbg_state (state_o[g])
    );
  end

  function automatic int ndig_of(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
  endfunction

  // ---------------- reference model ----------------
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    r    = full[W-1:0];
    c    = full[W];
    o    = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
`ifdef ADDSUB_SATURATE_EN
    if (o) r = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    z    = (r == '0);
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int hold,
                        output logic [W-1:0] r, output logic c, output logic o,
                        output logic z, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready[idx] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_i[idx] = a; b_i[idx] = b; sub_i[idx] = s; in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    lat = 0;
    // Operands are scrambled during RUN; the captured values must be what counts.
    while (!out_valid[idx] && lat < 40) begin
      a_i[idx] = W'($urandom); b_i[idx] = W'($urandom); sub_i[idx] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    r = result_o[idx]; c = cout_o[idx]; o = ovf_o[idx]; z = zero_o[idx];
    repeat (hold) begin @(posedge clk); #1; end
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks += 6;
      if (in_ready[i] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready idx=%0d got=%b exp=1", i, in_ready[i]); end
      if (out_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid idx=%0d got=%b exp=0", i, out_valid[i]); end
      if (result_o[i] !== '0)    begin errors++; $display("FAIL reset_result idx=%0d got=%h exp=0", i, result_o[i]); end
      if ({cout_o[i], ovf_o[i], zero_o[i]} !== 3'b000)
        begin errors++; $display("FAIL reset_flags idx=%0d got=%b exp=000", i, {cout_o[i], ovf_o[i], zero_o[i]}); end
      if (state_o[i] !== 2'd0)   begin errors++; $display("FAIL reset_state idx=%0d got=%0d exp=0", i, state_o[i]); end
      if (cout_o[i] !== 1'b0)    begin errors++; $display("FAIL reset_cout idx=%0d got=%b exp=0", i, cout_o[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic check_op(input string name, input int idx, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
    logic [W-1:0] r; logic c, o, z; int lat;
    run_op(idx, a, b, s, 0, r, c, o, z, lat);
    checks += 5;
    if (r !== er) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, r, er); end
    if (c !== ec) begin errors++; $display("FAIL %s_cout got=%b exp=%b", name, c, ec); end
    if (o !== eo) begin errors++; $display("FAIL %s_ovf got=%b exp=%b", name, o, eo); end
    if (z !== ez) begin errors++; $display("FAIL %s_zero got=%b exp=%b", name, z, ez); end
    if (lat !== ndig_of(idx)) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, ndig_of(idx)); end
  endtask

  task automatic test_add();
    check_op("add_1234_0fff", 1, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    check_op("sub_5_5", 1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    check_op("sub_0_1", 1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
`ifdef ADDSUB_SATURATE_EN
    check_op("ovf_add", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    check_op("ovf_sub", 1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    check_op("ovf_add", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    check_op("ovf_sub", 1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    a_i[1] = 16'h1111; b_i[1] = 16'h2222; sub_i[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 40) begin
      a_i[1] = W'($urandom); b_i[1] = W'($urandom); sub_i[1] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    // A request offered during DONE must be ignored.
    in_valid[1] = 1'b1; a_i[1] = 16'hAAAA; b_i[1] = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks += 4;
      if (result_o[1] !== 16'h3333) begin errors++; $display("FAIL bp_result cyc=%0d got=%h exp=3333", k, result_o[1]); end
      if (out_valid[1] !== 1'b1)    begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, out_valid[1]); end
      if (in_ready[1] !== 1'b0)     begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready[1]); end
      if ({cout_o[1], ovf_o[1], zero_o[1]} !== 3'b000)
        begin errors++; $display("FAIL bp_flags cyc=%0d got=%b exp=000", k, {cout_o[1], ovf_o[1], zero_o[1]}); end
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0; in_valid[1] = 1'b0;
    checks += 3;
    if (in_ready[1] !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready[1]); end
    if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid[1]); end
    if (state_o[1] !== 2'd0)   begin errors++; $display("FAIL bp_release_state got=%0d exp=0", state_o[1]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_i[1] = 16'hFFFF; b_i[1] = 16'h0001; sub_i[1] = 1'b1; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 4;
    if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid[1]); end
    if (in_ready[1] !== 1'b1)  begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready[1]); end
    if (result_o[1] !== '0)    begin errors++; $display("FAIL rmid_result got=%h exp=0", result_o[1]); end
    if (state_o[1] !== 2'd0)   begin errors++; $display("FAIL rmid_state got=%0d exp=0", state_o[1]); end
    check_op("rmid_00ff_1", 1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard sweep ----------------
  task automatic sweep_one(input int idx);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] corner [5];
    logic [W-1:0] a, b, r, er, got_exp;
    logic s, c, o, z, ec, eo, ez;
    int lat;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      s = 1'($urandom);
      model(a, b, s, er, ec, eo, ez);
      exp_q.push_back(er);
      run_op(idx, a, b, s, $urandom_range(0, 2), r, c, o, z, lat);
      got_exp = exp_q.pop_front();
      checks += 5;
      if (r !== got_exp) begin errors++; $display("FAIL sweep_result idx=%0d a=%h b=%h sub=%b got=%h exp=%h", idx, a, b, s, r, got_exp); end
      if (c !== ec) begin errors++; $display("FAIL sweep_cout idx=%0d a=%h b=%h sub=%b got=%b exp=%b", idx, a, b, s, c, ec); end
      if (o !== eo) begin errors++; $display("FAIL sweep_ovf idx=%0d a=%h b=%h sub=%b got=%b exp=%b", idx, a, b, s, o, eo); end
      if (z !== ez) begin errors++; $display("FAIL sweep_zero idx=%0d a=%h b=%h sub=%b got=%b exp=%b", idx, a, b, s, z, ez); end
      if (lat !== ndig_of(idx)) begin errors++; $display("FAIL sweep_latency idx=%0d got=%0d exp=%0d", idx, lat, ndig_of(idx)); end
    end
  endtask

  task automatic test_random_sweep();
    fork
      sweep_one(0);
      sweep_one(1);
      sweep_one(2);
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; sub_i[i] = 1'b0;
      a_i[i] = '0; b_i[i] = '0;
    end
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor. Each cycle it processes one DIGIT-bit slice of WIDTH-bit operands, LSB slice first, through a registered carry. Valid/ready handshakes on input and output. Successor to the 4-bit ripple adder/subtractor: generic width, fewer adder cells in exchange for latency, status flags, and backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, cycles spent in RUN.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand/op request.
in_ready  out  1  block can accept a request.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
out_valid  out  1  result and flags are valid.
out_ready  in  1  consumer accepts the result.
result  out  WIDTH  sum/difference.
cout  out  1  carry out of MSB (in sub mode 1 = no borrow).
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  out  1  result == 0 (after saturation, if enabled).

Behaviour:
- Reset: all of the following hold for the cycle after rst is sampled high.
  - State is IDLE.
  - in_ready=1, out_valid=0.
  - result, cout, ovf and zero are 0.
  - Operand, carry and count registers are 0.
- rst aborts any operation in progress. The partial result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a, b, sub; carry <= sub; cnt <= 0; go to RUN.
  - a, b and sub are ignored in all other cycles; changes after the accept cycle have no effect.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle:
    - Digit i = A[i*DIGIT +: DIGIT] + (B slice XOR {DIGIT{sub}}) + carry.
    - Store the digit into result slice i, and register its carry-out.
    - cnt <= cnt + 1.
  - On the cycle cnt == NDIG-1:
    - cout <= digit carry-out.
    - ovf <= carry into bit DIGIT-1 of the digit XOR its carry-out.
    - zero is computed from the final result.
    - Go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready: go to IDLE (out_valid=0, in_ready=1 next cycle).
  - in_ready stays 0 while in DONE; a request cannot be accepted in the same cycle as a result handoff.
- Latency: out_valid rises exactly NDIG cycles after the accept edge.
- Minimum initiation interval: NDIG+2 cycles with out_ready held high.
- NDIG=1 (WIDTH==DIGIT): RUN lasts one cycle and the block behaves as a registered single-shot adder.
- Carry chain wraps only within one operation. Carry is reloaded with sub on every accept; no carry leaks between operations.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the request is not queued.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined:
  - On ovf=1, result is clamped to the signed limit in the direction of the true result.
  - Captured A[MSB]=0 gives 0111..1; A[MSB]=1 gives 1000..0.
  - Clamp is applied when entering DONE; ovf and cout still report the unsaturated operation; zero reflects the clamped result.
- Undefined: result wraps modulo 2^WIDTH. No saturation logic is built.

Decomposition:
- Shared package addsub_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - Default WIDTH/DIGIT constants.
  - Function computing the count-register width, clog2(NDIG) with a minimum of 1.
- Sub-module addsub_digit (combinational, parametrised by DIGIT):
  - Built as a ripple of DIGIT full-adder cells.
  - Inputs: a, b, sub, cin. Outputs: sum, cout, c_msb_in (carry into the top bit, for ovf).
- The top level holds the FSM, the operand/result registers and the optional saturation.

Test Plan:
1. WIDTH=16, DIGIT=4, sub=0: 0x1234 + 0x0FFF -> result 0x2233, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after the accept edge.
2. sub=1: 0x0005 - 0x0005 -> result 0x0000, zero=1, cout=1, ovf=0. Also 0x0000 - 0x0001 -> 0xFFFF, cout=0, ovf=0.
3. Overflow, sub=0: 0x7FFF + 0x0001.
   - Without the macro: 0x8000, ovf=1, cout=0.
   - With ADDSUB_SATURATE_EN: 0x7FFF, ovf=1.
   - Also 0x8000 - 0x0001 -> 0x7FFF (ovf=1) unsaturated, 0x8000 saturated.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/flags stable, out_valid=1, in_ready=0; raise out_ready -> in_ready=1 next cycle. Operand changes during RUN do not alter the result.
5. Reset mid-operation: assert rst after 2 RUN cycles -> next cycle out_valid=0, in_ready=1, result=0. A following 0x00FF + 0x0001 gives 0x0100 with no stale carry.
6. Parameter sweep: DIGIT=1, 4, 16 with WIDTH=16, 1000 random ops each (mixed sub) vs a reference model -> exact match on result/cout/ovf/zero; latency equals NDIG.
